// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main Moore controller for the 32-bit multi-cycle MIPS datapath. It sequences
// each instruction through fetch, decode, execute, memory and write-back over
// 2 to 5 cycles. It drives every mux select and write enable of the datapath,
// and it contains the ALU decoder.
//
// Ports
//   CLK         in   system clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   Op[5:0]     in   IR[31:26] opcode
//   Funct[5:0]  in   IR[5:0] function field (R-type)
//   Zero        in   ALU result == 0
//   IorD        out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite    out  memory write enable
//   IRWrite     out  instruction register load
//   RegDst      out  write register select (0 = rt, 1 = rd)
//   MemtoReg    out  register write data select (0 = ALUOut, 1 = MDR)
//   RegWrite    out  register file write enable
//   ALUSrcA     out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB     out  ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   PCSrc[1:0]  out  PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   PCEn        out  PC load enable
//   ALUControl  out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   InstrDone   out  high in the final state of each instruction
//   State[3:0]  out  current state code (debug)
//
// Build option
//   CTRL_BNE_EN  When defined, opcode 000101 (bne) shares the BREXEC state with
//                beq. A flag registered in DECODE inverts the branch condition.
//                When undefined, 000101 is an undefined opcode (2-cycle NOP).
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BREXEC = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU decoder: unknown funct codes fall back to add.
    function automatic logic [2:0] alu_decode(input aluop_t aluop, input logic [5:0] funct);
        logic [2:0] ctl;
        case (aluop)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: ctl = ALU_ADD;
                    6'b100010: ctl = ALU_SUB;
                    6'b100100: ctl = ALU_AND;
                    6'b100101: ctl = ALU_OR;
                    6'b101010: ctl = ALU_SLT;
                    default:   ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Opcodes that are treated as branches in BREXEC.
    function automatic logic is_branch_op(input logic [5:0] op);
`ifdef CTRL_BNE_EN
        return (op == OP_BEQ) || (op == OP_BNE);
`else
        return (op == OP_BEQ);
`endif
    endfunction

    // Execute state chosen from DECODE; S_FETCH marks an undefined opcode.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        if ((op == OP_LW) || (op == OP_SW)) begin
            nxt = S_MEMADR;
        end else if (op == OP_RTYPE) begin
            nxt = S_REXEC;
        end else if (is_branch_op(op)) begin
            nxt = S_BREXEC;
        end else if (op == OP_ADDI) begin
            nxt = S_ADDIEX;
        end else if (op == OP_J) begin
            nxt = S_JEX;
        end else begin
            nxt = S_FETCH;
        end
        return nxt;
    endfunction

    state_t state_q;
    state_t state_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Branch polarity flag (bne support)
    // -------------------------------------------------------------------------
    logic branch_cond;

`ifdef CTRL_BNE_EN
    logic bne_q;
    logic bne_d;

    // Captured in DECODE so BREXEC can tell bne from beq without re-decoding.
    always_comb begin
        bne_d = bne_q;
        if (state_q == S_DECODE) begin
            bne_d = (Op == OP_BNE);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            bne_q <= 1'b0;
        end else begin
            bne_q <= bne_d;
        end
    end

    assign branch_cond = Zero ^ bne_q;
`else
    assign branch_cond = Zero;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = decode_next(Op);
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BREXEC: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JEX:    state_d = S_FETCH;
            default:  state_d = S_FETCH;   // codes 12..15 recover to FETCH
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs (raw, before reset gating)
    // -------------------------------------------------------------------------
    logic   iord_c;
    logic   memwrite_c;
    logic   irwrite_c;
    logic   regdst_c;
    logic   memtoreg_c;
    logic   regwrite_c;
    logic   alusrca_c;
    logic   [1:0] alusrcb_c;
    logic   [1:0] pcsrc_c;
    logic   pcwrite_c;
    logic   branch_c;
    logic   done_c;
    aluop_t aluop_c;

    always_comb begin
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        done_c     = 1'b0;
        aluop_c    = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                iord_c    = 1'b0;
                irwrite_c = 1'b1;
                alusrca_c = 1'b0;
                alusrcb_c = 2'b01;
                aluop_c   = ALUOP_ADD;
                pcsrc_c   = 2'b00;
                pcwrite_c = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes PC+4 + (SignImm<<2) for a possible branch.
                alusrca_c = 1'b0;
                alusrcb_c = 2'b11;
                aluop_c   = ALUOP_ADD;
                // Undefined opcodes retire here as a NOP.
                done_c    = (decode_next(Op) == S_FETCH);
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                aluop_c   = ALUOP_ADD;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
            end
            S_MEMWB: begin
                regdst_c   = 1'b0;
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_REXEC: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b00;
                aluop_c   = ALUOP_FUNCT;
            end
            S_RWB: begin
                regdst_c   = 1'b1;
                memtoreg_c = 1'b0;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_BREXEC: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b00;
                aluop_c   = ALUOP_SUB;
                pcsrc_c   = 2'b01;
                branch_c  = 1'b1;
                done_c    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                aluop_c   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                regdst_c   = 1'b0;
                memtoreg_c = 1'b0;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_JEX: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
                done_c    = 1'b1;
            end
            default: begin
                // Illegal codes: everything stays at its default of 0.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    // Write enables and InstrDone are gated by Reset so that no write can pulse
    // while reset is asserted, even before the asynchronous clear settles the
    // state register. Selects simply follow the (FETCH) state.
    assign IorD       = iord_c;
    assign RegDst     = regdst_c;
    assign MemtoReg   = memtoreg_c;
    assign ALUSrcA    = alusrca_c;
    assign ALUSrcB    = alusrcb_c;
    assign PCSrc      = pcsrc_c;
    assign ALUControl = alu_decode(aluop_c, Funct);
    assign State      = state_q;

    assign MemWrite  = memwrite_c & ~Reset;
    assign IRWrite   = irwrite_c  & ~Reset;
    assign RegWrite  = regwrite_c & ~Reset;
    assign InstrDone = done_c     & ~Reset;
    assign PCEn      = (pcwrite_c | (branch_c & branch_cond)) & ~Reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       CLK;
    logic       Reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [2:0] ALUControl;
    logic       InstrDone;
    logic [3:0] State;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control_fsm dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl),
        .InstrDone  (InstrDone),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Write enables and done flag packed {PCEn,IRWrite,MemWrite,RegWrite,InstrDone}.
    function automatic logic [4:0] we();
        return {PCEn, IRWrite, MemWrite, RegWrite, InstrDone};
    endfunction

    initial begin
        Reset = 1'b1;
        Op    = 6'b000000;
        Funct = 6'b000000;
        Zero  = 1'b0;

        // Reset held for 20 ns
        #2;
        check("rst_state", State, 4'd0);
        check("rst_en", we(), 5'b00000);
        check("rst_alusrcb", ALUSrcB, 2'b01);
        @(negedge CLK);                     // t = 10
        @(negedge CLK);                     // t = 20
        Reset = 1'b0;
        Op    = 6'b100011;                  // lw
        #1;
        check("fetch_state", State, 4'd0);
        check("fetch_en", we(), 5'b11000);
        check("fetch_iord", IorD, 1'b0);
        check("fetch_alu", ALUControl, 3'b010);

        // lw: 0,1,2,3,4
        step();
        check("lw_s1", State, 4'd1);
        check("dec_srcb", ALUSrcB, 2'b11);
        check("dec_en", we(), 5'b00000);
        step();
        check("lw_s2", State, 4'd2);
        check("memadr_sel", {ALUSrcA, ALUSrcB}, 3'b110);
        step();
        check("lw_s3", State, 4'd3);
        check("memrd_iord", IorD, 1'b1);
        step();
        check("lw_s4", State, 4'd4);
        check("memwb_en", we(), 5'b00011);
        check("memwb_sel", {RegDst, MemtoReg}, 2'b01);
        step();
        check("lw_end", State, 4'd0);

        // R-type slt, then and
        Op = 6'b000000; Funct = 6'b101010;
        step(); check("r1_s1", State, 4'd1);
        step(); check("r1_s6", State, 4'd6);
        check("slt_ctl", ALUControl, 3'b111);
        check("rexec_sel", {ALUSrcA, ALUSrcB}, 3'b100);
        step(); check("r1_s7", State, 4'd7);
        check("rwb_en", we(), 5'b00011);
        check("rwb_sel", {RegDst, MemtoReg}, 2'b10);
        step(); check("r1_end", State, 4'd0);
        Funct = 6'b100100;
        step(); step();
        check("r2_s6", State, 4'd6);
        check("and_ctl", ALUControl, 3'b000);
        Funct = 6'b111111;
        #1 check("dflt_ctl", ALUControl, 3'b010);
        Funct = 6'b100101;
        #1 check("or_ctl", ALUControl, 3'b001);
        Funct = 6'b100100;
        step(); check("r2_s7", State, 4'd7);
        step(); check("r2_end", State, 4'd0);

        // beq taken then not taken
        Op = 6'b000100; Zero = 1'b1;
        step(); check("beq1_s1", State, 4'd1);
        step(); check("beq1_s8", State, 4'd8);
        check("beq_taken_en", we(), 5'b10001);
        check("beq_pcsrc", PCSrc, 2'b01);
        check("beq_sub", ALUControl, 3'b110);
        step(); check("beq1_end", State, 4'd0);
        Zero = 1'b0;
        step(); step();
        check("beq2_s8", State, 4'd8);
        check("beq_nt_en", we(), 5'b00001);
        step(); check("beq2_end", State, 4'd0);

        // addi
        Op = 6'b001000;
        step(); step();
        check("addi_s9", State, 4'd9);
        check("addiex_sel", {ALUSrcA, ALUSrcB}, 3'b110);
        step(); check("addi_s10", State, 4'd10);
        check("addiwb_en", we(), 5'b00011);
        check("addiwb_sel", {RegDst, MemtoReg}, 2'b00);
        step(); check("addi_end", State, 4'd0);

        // j
        Op = 6'b000010;
        step(); step();
        check("j_s11", State, 4'd11);
        check("j_en", we(), 5'b10001);
        check("j_pcsrc", PCSrc, 2'b10);
        step(); check("j_end", State, 4'd0);

        // undefined opcode: 2-cycle NOP
        Op = 6'b111111;
        step(); check("nop_s1", State, 4'd1);
        check("nop_en", we(), 5'b00001);
        step(); check("nop_end", State, 4'd0);

        // bne with Zero = 0
        Op = 6'b000101; Zero = 1'b0;
        step(); check("bne_s1", State, 4'd1);
`ifdef CTRL_BNE_EN
        check("bne_dec_en", we(), 5'b00000);
        step(); check("bne_s8", State, 4'd8);
        check("bne_taken_en", we(), 5'b10001);
        Zero = 1'b1;
        #1 check("bne_nt_en", we(), 5'b00001);
        Zero = 1'b0;
`else
        check("bne_nop_en", we(), 5'b00001);
`endif
        step(); check("bne_end", State, 4'd0);

        // sw aborted by reset in MEMWR
        Op = 6'b101011;
        step(); step();
        check("sw_s2", State, 4'd2);
        step(); check("sw_s5", State, 4'd5);
        check("memwr_en", we(), 5'b00101);
        check("memwr_iord", IorD, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("abort_state", State, 4'd0);
        check("abort_en", we(), 5'b00000);
        @(negedge CLK);
        check("abort_hold", State, 4'd0);
        Reset = 1'b0;
        #1 check("restart_en", we(), 5'b11000);
        step(); check("restart_s1", State, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
